// File: rtl/bs_fifo_epb_if.sv
// Bitstream FIFO port bundle: header/CAVLC/trailing write ports, per-byte
// valid/ready output stream and status flags.
interface bs_fifo_epb_if #(
  parameter int ADDR_W    = 7,
  parameter int HDR_BYTES = 3,
  parameter int DAT_BYTES = 8
);
  localparam int SH_INC_W = $clog2(HDR_BYTES + 1);
  localparam int CV_INC_W = $clog2(DAT_BYTES + 1);

  logic                     sh_we;
  logic [SH_INC_W-1:0]      sh_inc;
  logic [8*HDR_BYTES-1:0]   sh_bit;
  logic                     cavlc_we;
  logic [CV_INC_W-1:0]      cavlc_inc;
  logic [8*DAT_BYTES-1:0]   cavlc_bit;
  logic                     frame_done;
  logic [7:0]               rbsp_trailing;
  logic                     epb_en;
  logic                     slice_start;
  logic                     sh_rdy;
  logic                     cavlc_rdy;
  logic                     bs_valid;
  logic                     bs_ready;
  logic [7:0]               bs_o;
  logic                     bs_empty_o;
  logic [ADDR_W:0]          level_o;
  logic                     overflow_o;

  modport slave (
    input  sh_we, sh_inc, sh_bit, cavlc_we, cavlc_inc, cavlc_bit,
           frame_done, rbsp_trailing, epb_en, slice_start, bs_ready,
    output sh_rdy, cavlc_rdy, bs_valid, bs_o, bs_empty_o, level_o, overflow_o
  );

  modport master (
    output sh_we, sh_inc, sh_bit, cavlc_we, cavlc_inc, cavlc_bit,
           frame_done, rbsp_trailing, epb_en, slice_start, bs_ready,
    input  sh_rdy, cavlc_rdy, bs_valid, bs_o, bs_empty_o, level_o, overflow_o
  );
endinterface

// File: rtl/bs_fifo_epb.sv
// Byte FIFO from entropy coder to byte stream with optional 0x03 emulation
// prevention; first byte out one cycle after write, holds output while !bs_ready.
module bs_fifo_epb #(
  parameter int ADDR_W    = 7,
  parameter int HDR_BYTES = 3,
  parameter int DAT_BYTES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  bs_fifo_epb_if.slave  bus
);
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int CNT_W    = ADDR_W + 1;
  localparam int SH_INC_W = $clog2(HDR_BYTES + 1);
  localparam int CV_INC_W = $clog2(DAT_BYTES + 1);
  localparam int MAX_B    = (HDR_BYTES > DAT_BYTES) ? HDR_BYTES : DAT_BYTES;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  level;
  logic [1:0]        zrun;
  logic              overflow_q;
  logic              bs_valid_q;
  logic [7:0]        bs_o_q;

  logic [CNT_W-1:0]  free_c;
  logic [CNT_W-1:0]  sh_len;
  logic [CNT_W-1:0]  cv_len;
  logic              wr_req;
  logic [CNT_W-1:0]  wr_len;
  logic [7:0]        wr_byte [MAX_B];
  logic              wr_acc;
  logic              wr_rej;
  logic [CNT_W-1:0]  wr_cnt;

  logic              load;
  logic [7:0]        cand;
  logic              insert_epb;
  logic              pop;
  logic              bs_valid_n;
  logic [7:0]        bs_o_n;
  logic [1:0]        zrun_n;
  logic [CNT_W-1:0]  level_n;

  assign free_c = DEPTH_C - level;

  // Oversized byte counts saturate at the port width.
  always_comb begin
    sh_len = CNT_W'(bus.sh_inc);
    if (bus.sh_inc > SH_INC_W'(HDR_BYTES))
      sh_len = CNT_W'(HDR_BYTES);
    cv_len = CNT_W'(bus.cavlc_inc);
    if (bus.cavlc_inc > CV_INC_W'(DAT_BYTES))
      cv_len = CNT_W'(DAT_BYTES);
  end

  always_comb begin
    wr_req = 1'b0;
    wr_len = '0;
    for (int i = 0; i < MAX_B; i++)
      wr_byte[i] = 8'h00;
    if (bus.sh_we) begin
      wr_req = 1'b1;
      wr_len = sh_len;
      for (int i = 0; i < HDR_BYTES; i++)
        wr_byte[i] = bus.sh_bit[8*(HDR_BYTES-1-i) +: 8];
    end else if (bus.cavlc_we) begin
      wr_req = 1'b1;
      wr_len = cv_len;
      for (int i = 0; i < DAT_BYTES; i++)
        wr_byte[i] = bus.cavlc_bit[8*(DAT_BYTES-1-i) +: 8];
    end else if (bus.frame_done && (bus.rbsp_trailing != 8'h00)) begin
      wr_req = 1'b1;
      wr_len = CNT_W'(1);
      wr_byte[0] = bus.rbsp_trailing;
    end
  end

  assign wr_acc = wr_req && (free_c >= wr_len);
  assign wr_rej = wr_req && !wr_acc;
  assign wr_cnt = wr_acc ? wr_len : '0;

  assign load       = !bs_valid_q || bus.bs_ready;
  assign cand       = mem[rd_ptr];
  assign insert_epb = bus.epb_en && (zrun == 2'd2) && (cand <= 8'h03);
  assign pop        = load && (level != '0) && !insert_epb;

  // An inserted 0x03 occupies the output slot while the candidate stays queued.
  always_comb begin
    bs_valid_n = bs_valid_q;
    bs_o_n     = bs_o_q;
    zrun_n     = zrun;
    if (load) begin
      if (level != '0) begin
        bs_valid_n = 1'b1;
        if (insert_epb) begin
          bs_o_n = 8'h03;
          zrun_n = 2'd0;
        end else begin
          bs_o_n = cand;
          if (cand == 8'h00)
            zrun_n = (zrun == 2'd2) ? 2'd2 : 2'(zrun + 2'd1);
          else
            zrun_n = 2'd0;
        end
      end else begin
        bs_valid_n = 1'b0;
        bs_o_n     = 8'h00;
      end
    end
    if (!bus.epb_en || bus.slice_start)
      zrun_n = 2'd0;
  end

  assign level_n = level + wr_cnt - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < MAX_B; i++)
        if (CNT_W'(i) < wr_len)
          mem[wr_ptr + ADDR_W'(i)] <= wr_byte[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      zrun       <= 2'd0;
      overflow_q <= 1'b0;
      bs_valid_q <= 1'b0;
      bs_o_q     <= 8'h00;
    end else begin
      wr_ptr     <= wr_ptr + wr_cnt[ADDR_W-1:0];
      rd_ptr     <= rd_ptr + ADDR_W'(pop);
      level      <= level_n;
      zrun       <= zrun_n;
      overflow_q <= overflow_q | wr_rej;
      bs_valid_q <= bs_valid_n;
      bs_o_q     <= bs_o_n;
    end
  end

  assign bus.sh_rdy     = free_c >= CNT_W'(HDR_BYTES);
  assign bus.cavlc_rdy  = free_c >= CNT_W'(DAT_BYTES);
  assign bus.bs_valid   = bs_valid_q;
  assign bus.bs_o       = bs_o_q;
  assign bus.bs_empty_o = (level == '0) && !bs_valid_q && !bus.frame_done;
  assign bus.level_o    = level;
  assign bus.overflow_o = overflow_q;

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n) level <= DEPTH_C);
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bs_valid_q && !bus.bs_ready) |=> (bs_valid_q && $stable(bs_o_q)));
endmodule

// File: tb/tb_bs_fifo_epb.sv
// Bench for bs_fifo_epb: vector table plus scenario sequences, with a byte
// scoreboard fed from a stream-level emulation-prevention model.
module tb_bs_fifo_epb;
  localparam int ADDR_W    = 7;
  localparam int HDR_BYTES = 3;
  localparam int DAT_BYTES = 8;
  localparam int DEPTH     = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bs_fifo_epb_if #(.ADDR_W(ADDR_W), .HDR_BYTES(HDR_BYTES), .DAT_BYTES(DAT_BYTES)) bus ();

  bs_fifo_epb #(.ADDR_W(ADDR_W), .HDR_BYTES(HDR_BYTES), .DAT_BYTES(DAT_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_e;
  logic       epb_m = 1'b0;
  int         mz = 0;

  typedef struct {
    logic        sh;
    logic        cv;
    logic        fd;
    int          sh_inc;
    int          cv_inc;
    logic [63:0] dat;
    logic [7:0]  trl;
    int          exp_level;
    logic        exp_valid;
    logic [7:0]  exp_bs;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference byte stream: 0x03 goes in front of any byte <= 3 after two zeros.
  function automatic void push_exp(input logic [7:0] b);
    if (epb_m && mz == 2 && b <= 8'h03) begin
      exp_q.push_back(8'h03);
      mz = 0;
    end
    exp_q.push_back(b);
    if (epb_m && b == 8'h00) mz = (mz == 2) ? 2 : mz + 1;
    else mz = 0;
  endfunction

  task automatic model_write(input logic sh, input logic cv, input logic fd, input int sh_inc,
                             input int cv_inc, input logic [63:0] dat, input logic [7:0] trl);
    int n;
    if (sh) begin
      n = (sh_inc > HDR_BYTES) ? HDR_BYTES : sh_inc;
      for (int i = 0; i < n; i++) push_exp(dat[8*(HDR_BYTES-1-i) +: 8]);
    end else if (cv) begin
      n = (cv_inc > DAT_BYTES) ? DAT_BYTES : cv_inc;
      for (int i = 0; i < n; i++) push_exp(dat[8*(DAT_BYTES-1-i) +: 8]);
    end else if (fd && trl != 8'h00) begin
      push_exp(trl);
    end
  endtask

  task automatic idle();
    bus.sh_we = 1'b0;  bus.sh_inc = '0;  bus.sh_bit = '0;
    bus.cavlc_we = 1'b0;  bus.cavlc_inc = '0;  bus.cavlc_bit = '0;
    bus.frame_done = 1'b0;  bus.rbsp_trailing = 8'h00;  bus.slice_start = 1'b0;
  endtask

  task automatic drive(input logic sh, input logic cv, input logic fd, input int sh_inc,
                       input int cv_inc, input logic [63:0] dat, input logic [7:0] trl);
    bus.sh_we = sh;  bus.sh_inc = 2'(sh_inc);  bus.sh_bit = dat[23:0];
    bus.cavlc_we = cv;  bus.cavlc_inc = 4'(cv_inc);  bus.cavlc_bit = dat;
    bus.frame_done = fd;  bus.rbsp_trailing = trl;
  endtask

  // One write cycle; model=0 for writes expected to be dropped or flushed.
  task automatic step(input logic sh, input logic cv, input logic fd, input int sh_inc,
                      input int cv_inc, input logic [63:0] dat, input logic [7:0] trl, input logic model);
    drive(sh, cv, fd, sh_inc, cv_inc, dat, trl);
    if (model) model_write(sh, cv, fd, sh_inc, cv_inc, dat, trl);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    bus.bs_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    mz = 0;
    check("rst_valid", bus.bs_valid, 0);
    check("rst_bs_o", bus.bs_o, 0);
    check("rst_level", bus.level_o, 0);
    check("rst_overflow", bus.overflow_o, 0);
    check("rst_sh_rdy", bus.sh_rdy, 1);
    check("rst_cavlc_rdy", bus.cavlc_rdy, 1);
    check("rst_empty", bus.bs_empty_o, 1);
  endtask

  task automatic drain(input string name);
    bus.bs_ready = 1'b1;
    for (int c = 0; c < 600 && exp_q.size() > 0; c++) @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_missing_bytes"}, exp_q.size(), 0);
    check({name, "_idle_valid"}, bus.bs_valid, 0);
  endtask

  task automatic pulse_slice_start();
    bus.slice_start = 1'b1;
    @(posedge clk); #1;
    bus.slice_start = 1'b0;
    mz = 0;
  endtask

  // Scoreboard: a byte transfers at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (bus.bs_valid === 1'b1 && bus.bs_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream_extra: got byte 0x%0h, expected no byte", bus.bs_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.bs_o !== mon_e) begin
          fails++;
          $display("FAIL stream_byte: got 0x%0h, expected 0x%0h", bus.bs_o, mon_e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int          p;

    //            sh cv fd shi cvi dat                     trl    lvl val bs
    tbl[0] = '{1'b1, 1'b0, 1'b0, 3, 0, 64'h0000_0000_005A_0001, 8'h00,  3, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 0, 2, 64'h6742_0000_0000_0000, 8'h00,  4, 1'b1, 8'h5A};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 0, 9, 64'h1122_3344_5566_7788, 8'h00, 12, 1'b1, 8'h5A};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 0, 8, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 12, 1'b1, 8'h5A};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 0, 0, 64'h0,                   8'h80, 13, 1'b1, 8'h5A};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 0, 0, 64'h0,                   8'h00, 13, 1'b1, 8'h5A};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 3, 0, 64'h0000_0000_00AB_CDEF, 8'h55, 16, 1'b1, 8'h5A};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 0, 0, 64'h9999_9999_9999_9999, 8'h00, 16, 1'b1, 8'h5A};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 0, 8, 64'h0102_0304_0506_0708, 8'h00, 24, 1'b1, 8'h5A};

    rst_n = 1'b0;
    bus.epb_en = 1'b0;
    bus.bs_ready = 1'b0;
    idle();
    do_reset();

    // Vector table under backpressure: clamping, priority, no-op writes.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].sh, tbl[i].cv, tbl[i].fd, tbl[i].sh_inc, tbl[i].cv_inc, tbl[i].dat, tbl[i].trl, 1'b1);
      check($sformatf("tbl%0d_level", i), bus.level_o, tbl[i].exp_level);
      check($sformatf("tbl%0d_valid", i), bus.bs_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d_bs_o", i), bus.bs_o, tbl[i].exp_bs);
      check($sformatf("tbl%0d_overflow", i), bus.overflow_o, 0);
    end
    drain("tbl");

    // Header then data: first byte visible after the second edge.
    do_reset();
    bus.bs_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3, 0, 64'h0000_0000_0000_0001, 8'h00);
    model_write(1'b1, 1'b0, 1'b0, 3, 0, 64'h0000_0000_0000_0001, 8'h00);
    @(posedge clk); #1;
    check("hd_edge1_valid", bus.bs_valid, 0);
    idle();
    step(1'b0, 1'b1, 1'b0, 0, 2, 64'h6742_0000_0000_0000, 8'h00, 1'b1);
    check("hd_edge2_valid", bus.bs_valid, 1);
    check("hd_edge2_bs_o", bus.bs_o, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("hd_stream%0d_valid", c), bus.bs_valid, 1);
    end
    drain("hd");

    // Emulation prevention, pass-through of 00 00 04, slice_start clearing.
    do_reset();
    bus.epb_en = 1'b1;
    epb_m = 1'b1;
    bus.bs_ready = 1'b1;
    pulse_slice_start();
    step(1'b0, 1'b1, 1'b0, 0, 8, 64'h0000_0100_0000_0003, 8'h00, 1'b1);
    drain("epb_main");
    step(1'b0, 1'b1, 1'b0, 0, 3, 64'h0000_0400_0000_0000, 8'h00, 1'b1);
    drain("epb_04");
    step(1'b0, 1'b1, 1'b0, 0, 2, 64'h0, 8'h00, 1'b1);
    drain("epb_zeros");
    pulse_slice_start();
    step(1'b0, 1'b1, 1'b0, 0, 1, 64'h0100_0000_0000_0000, 8'h00, 1'b1);
    drain("epb_slice");

    // Backpressure to full, one dropped write, then ordered drain.
    do_reset();
    bus.epb_en = 1'b0;
    epb_m = 1'b0;
    step(1'b0, 1'b1, 1'b0, 0, 1, 64'hC000_0000_0000_0000, 8'h00, 1'b1);
    for (int w = 0; w < 16; w++) begin
      for (int j = 0; j < 8; j++) d[8*(7-j) +: 8] = 8'(w * 8 + j);
      step(1'b0, 1'b1, 1'b0, 0, 8, d, 8'h00, 1'b1);
    end
    check("full_level", bus.level_o, DEPTH);
    check("full_cavlc_rdy", bus.cavlc_rdy, 0);
    check("full_sh_rdy", bus.sh_rdy, 0);
    check("full_overflow_before", bus.overflow_o, 0);
    check("full_empty", bus.bs_empty_o, 0);
    step(1'b0, 1'b1, 1'b0, 0, 8, 64'hEEEE_EEEE_EEEE_EEEE, 8'h00, 1'b0);
    check("full_level_after_drop", bus.level_o, DEPTH);
    check("full_overflow_after", bus.overflow_o, 1);
    drain("full");
    check("full_overflow_sticky", bus.overflow_o, 1);

    // Continuous writes with output streaming: pointer wrap and concurrency.
    do_reset();
    bus.bs_ready = 1'b1;
    p = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.cavlc_rdy) begin
        for (int j = 0; j < 8; j++) d[8*(7-j) +: 8] = 8'(p + j);
        drive(1'b0, 1'b1, 1'b0, 0, 8, d, 8'h00);
        model_write(1'b0, 1'b1, 1'b0, 0, 8, d, 8'h00);
        p += 8;
      end else begin
        idle();
      end
      @(posedge clk); #1;
      check("wrap_level_le_depth", (bus.level_o <= DEPTH), 1);
    end
    idle();
    check("wrap_wrapped", (p > DEPTH), 1);
    drain("wrap");

    // Same-cycle header and CAVLC writes, then a lone trailing byte.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 2, 8, 64'h0000_0000_00AA_BB00, 8'h00, 1'b1);
    check("prio_level", bus.level_o, 2);
    check("prio_overflow", bus.overflow_o, 0);
    drain("prio");
    check("trl_empty_before", bus.bs_empty_o, 1);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 64'h0, 8'h80);
    model_write(1'b0, 1'b0, 1'b1, 0, 0, 64'h0, 8'h80);
    #1;
    check("trl_empty_during_fd", bus.bs_empty_o, 0);
    @(posedge clk); #1;
    check("trl_level", bus.level_o, 1);
    check("trl_empty_fd_held", bus.bs_empty_o, 0);
    idle();
    drain("trl");

    // Reset mid-stream with a non-zero zero-run pending.
    do_reset();
    bus.epb_en = 1'b1;
    epb_m = 1'b1;
    bus.bs_ready = 1'b1;
    step(1'b0, 1'b1, 1'b0, 0, 1, 64'h0, 8'h00, 1'b1);
    drain("mid_prep");
    bus.bs_ready = 1'b0;
    step(1'b0, 1'b1, 1'b0, 0, 8, 64'h0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 8, 64'h0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 4, 64'h0, 8'h00, 1'b0);
    check("mid_level_before_reset", bus.level_o, 19);
    check("mid_valid_before_reset", bus.bs_valid, 1);
    do_reset();
    bus.bs_ready = 1'b1;
    step(1'b0, 1'b1, 1'b0, 0, 1, 64'h0100_0000_0000_0000, 8'h00, 1'b1);
    drain("mid_after_01");
    step(1'b0, 1'b1, 1'b0, 0, 3, 64'h0000_0100_0000_0000, 8'h00, 1'b1);
    drain("mid_after_000001");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
